// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// the request record captured at accept.
package dmem_pkg;
   localparam int REQ_ADDR_W = 32;

   typedef enum logic [1:0] {
      SZ_BYTE    = 2'b00,
      SZ_HALF    = 2'b01,
      SZ_WORD    = 2'b10,
      SZ_ILLEGAL = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic [REQ_ADDR_W-1:0] addr;
      logic                  we;
      mem_size_e             size;
      logic                  is_unsigned;
      logic [31:0]           wdata;
      logic                  err;
   } dmem_req_t;
endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte mask and replicated write word for stores,
// lane extraction with zero/sign extension for loads.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] wdata,
   input  mem_size_e   size,
   input  logic [1:0]  lane,
   input  logic        is_unsigned,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata
);
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign rbyte = rword[{lane, 3'b000} +: 8];
   assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      be    = 4'b0000;
      wword = wdata;
      rdata = '0;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << lane;
            wword = {4{wdata[7:0]}};
            rdata = {{24{~is_unsigned & rbyte[7]}}, rbyte};
         end
         SZ_HALF: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
            rdata = {{16{~is_unsigned & rhalf[15]}}, rhalf};
         end
         SZ_WORD: begin
            be    = 4'b1111;
            rdata = rword;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store target over a word array with
// programmable wait states; stores commit on the edge that raises the response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   dmem_state_e           state, state_nx;
   logic [3:0]            cnt, cnt_nx;
   dmem_req_t             req_q, req_d, cur;
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic [IDX_W-1:0]      widx;
   logic [3:0]            be;
   logic [31:0]           wword, rdata_ext;
   logic                  accept, commit, oor, misalign;
   logic                  unused_addr_hi;

   assign req_ready_o = (state == IDLE);
   assign rsp_valid_o = (state == RESP);
   assign accept      = req_valid_i && req_ready_o;

   always_comb begin
      oor      = (req_addr_i >> (IDX_W + 2)) != '0;
      misalign = (mem_size_e'(req_size_i) == SZ_HALF && req_addr_i[0]) ||
                 (mem_size_e'(req_size_i) == SZ_WORD && req_addr_i[1:0] != 2'b00);
      req_d.addr        = REQ_ADDR_W'(req_addr_i);
      req_d.we          = req_we_i;
      req_d.size        = mem_size_e'(req_size_i);
      req_d.is_unsigned = req_unsigned_i;
      req_d.wdata       = req_wdata_i;
      req_d.err         = (mem_size_e'(req_size_i) == SZ_ILLEGAL) || misalign || oor;
   end

   // With zero latency the commit edge is the accept edge, so the live request is used.
   assign cur    = (state == IDLE) ? req_d : req_q;
   assign widx   = cur.addr[IDX_W+1:2];
   assign commit = (state_nx == RESP) && (state != RESP);
   assign unused_addr_hi = ^cur.addr[REQ_ADDR_W-1:IDX_W+2];

   dmem_lane_align u_align (
      .wdata       (cur.wdata),
      .size        (cur.size),
      .lane        (cur.addr[1:0]),
      .is_unsigned (cur.is_unsigned),
      .rword       (mem[widx]),
      .be          (be),
      .wword       (wword),
      .rdata       (rdata_ext)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: if (accept) begin
            if (LATENCY == 0) begin
               state_nx = RESP;
            end else begin
               state_nx = WAIT;
               cnt_nx   = 4'(LATENCY - 1);
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_nx = RESP;
            else             cnt_nx   = cnt - 4'd1;
         end
         RESP:    if (rsp_ready_i) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         req_q       <= '0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) req_q <= req_d;
         if (commit) begin
            rsp_err_o   <= cur.err;
            rsp_rdata_o <= (cur.err || cur.we) ? '0 : rdata_ext;
         end else if (state == RESP && state_nx == IDLE) begin
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (commit && cur.we && !cur.err) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance with driven rsp_ready and a
// LATENCY=0 instance with rsp_ready tied high, both against a byte-array model.
module tb_dmem_responder;
   localparam int DEPTH = 1024;
   localparam int LAT_A = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       req_valid = '0, req_we = '0, req_uns = '0;
   logic [1:0][1:0]  req_size = '0;
   logic [1:0][31:0] req_addr = '0, req_wdata = '0;
   logic             rsp_ready_a = 1'b0;
   logic             rdy_a, vld_a, er_a, rdy_b, vld_b, er_b;
   logic [31:0]      rd_a, rd_b;
   int               checks = 0, errors = 0, cyc = 0;
   logic [7:0]       mdl [2][128];

   always @(posedge clk) cyc++;

   dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid[0]), .req_ready_o(rdy_a), .req_addr_i(req_addr[0]),
      .req_we_i(req_we[0]), .req_size_i(req_size[0]), .req_unsigned_i(req_uns[0]),
      .req_wdata_i(req_wdata[0]), .rsp_valid_o(vld_a), .rsp_ready_i(rsp_ready_a),
      .rsp_rdata_o(rd_a), .rsp_err_o(er_a)
   );

   dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid[1]), .req_ready_o(rdy_b), .req_addr_i(req_addr[1]),
      .req_we_i(req_we[1]), .req_size_i(req_size[1]), .req_unsigned_i(req_uns[1]),
      .req_wdata_i(req_wdata[1]), .rsp_valid_o(vld_b), .rsp_ready_i(1'b1),
      .rsp_rdata_o(rd_b), .rsp_err_o(er_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Byte-addressed reference: error rules first, then little-endian access.
   function automatic void mdl_access(input int sel, input logic [31:0] a, input logic we,
                                      input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                                      output logic [31:0] rd, output logic er);
      int nb;
      logic [31:0] v;
      logic [63:0] m;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      er = (sz == 2'd3) || (a % nb != 0) || (a / 4 >= DEPTH);
      rd = '0;
      if (er) return;
      if (we) begin
         for (int i = 0; i < nb; i++) mdl[sel][a + i] = wd[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[sel][a + i];
         m = (64'd1 << (8 * nb)) - 64'd1;
         if (!uns && v[8*nb-1]) v = v | ~m[31:0];
         rd = v;
      end
   endfunction

   // Full transaction; entered and left on a negedge. hold>0 applies backpressure (DUT a only).
   task automatic xfer(input int sel, input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input int hold);
      logic [31:0] erd, rd0;
      logic eer, er0;
      int n;
      mdl_access(sel, a, we, sz, uns, wd, erd, eer);
      req_valid[sel] = 1'b1; req_addr[sel] = a; req_we[sel] = we;
      req_size[sel] = sz; req_uns[sel] = uns; req_wdata[sel] = wd;
      n = 0;
      while (!(sel == 1 ? rdy_b : rdy_a) && n < 20) begin @(negedge clk); n++; end
      chk("accept_timeout", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      req_valid[sel] = 1'b0; req_addr[sel] = $urandom; req_we[sel] = 1'($urandom);
      req_size[sel] = 2'($urandom); req_uns[sel] = 1'($urandom); req_wdata[sel] = $urandom;
      if (sel == 0) rsp_ready_a = 1'($urandom_range(0, 1));
      @(negedge clk);
      n = 1;
      while (!(sel == 1 ? vld_b : vld_a) && n < 40) begin @(negedge clk); n++; end
      chk("latency", 32'(n), (sel == 1) ? 32'd1 : 32'(LAT_A + 1));
      rd0 = (sel == 1) ? rd_b : rd_a;
      er0 = (sel == 1) ? er_b : er_a;
      chk("rdata", rd0, erd);
      chk("err", 32'(er0), 32'(eer));
      for (int i = 0; i < hold; i++) begin
         rsp_ready_a = 1'b0;
         req_valid[0] = 1'b1; req_addr[0] = $urandom_range(0, 127); req_we[0] = 1'b1;
         req_size[0] = 2'd0; req_wdata[0] = $urandom;
         @(negedge clk);
         chk("bp_valid", 32'(vld_a), 32'd1);
         chk("bp_rdata", rd_a, rd0);
         chk("bp_err", 32'(er_a), 32'(er0));
         chk("bp_ready", 32'(rdy_a), 32'd0);
      end
      req_valid[sel] = 1'b0;
      if (sel == 0) rsp_ready_a = 1'b1;
      @(posedge clk); #1;
      rsp_ready_a = 1'b0;
      @(negedge clk);
      chk("rsp_drop", 32'(sel == 1 ? vld_b : vld_a), 32'd0);
      chk("rsp_clr_rdata", (sel == 1) ? rd_b : rd_a, 32'd0);
      chk("rsp_clr_err", 32'(sel == 1 ? er_b : er_a), 32'd0);
      chk("ready_back", 32'(sel == 1 ? rdy_b : rdy_a), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen, n, prev, acc;
      logic [31:0] a, erd;
      logic [1:0] sz;
      logic eer;
      for (int s = 0; s < 2; s++) for (int i = 0; i < 128; i++) mdl[s][i] = 8'h00;

      #2;
      chk("rst_ready", 32'(rdy_a), 32'd1);
      chk("rst_valid", 32'(vld_a), 32'd0);
      chk("rst_rdata", rd_a, 32'd0);
      chk("rst_err", 32'(er_a), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("ready_after_rst", 32'(rdy_a), 32'd1);

      for (int w = 0; w < 32; w++) xfer(0, 32'(4 * w), 1'b1, 2'd2, 1'b0, 32'd0, 0);

      // directed scenarios
      xfer(0, 32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 0);
      xfer(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'd0, 0);
      xfer(0, 32'h13, 1'b1, 2'd0, 1'b0, 32'h00000080, 0);
      xfer(0, 32'h13, 1'b0, 2'd0, 1'b0, 32'd0, 0);
      xfer(0, 32'h13, 1'b0, 2'd0, 1'b1, 32'd0, 0);
      xfer(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'd0, 0);
      xfer(0, 32'h20, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 0);
      xfer(0, 32'h21, 1'b0, 2'd1, 1'b0, 32'd0, 0);
      xfer(0, 32'h22, 1'b1, 2'd2, 1'b0, 32'h11111111, 0);
      xfer(0, 32'h20, 1'b1, 2'd3, 1'b0, 32'h22222222, 0);
      xfer(0, 32'(4 * DEPTH), 1'b0, 2'd2, 1'b0, 32'd0, 0);
      xfer(0, 32'h20, 1'b0, 2'd2, 1'b0, 32'd0, 0);
      xfer(0, 32'h22, 1'b0, 2'd1, 1'b0, 32'd0, 0);
      xfer(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'd0, 5);

      // reset while a store is waiting: no response, no commit
      xfer(0, 32'h40, 1'b1, 2'd2, 1'b0, 32'd0, 0);
      req_valid[0] = 1'b1; req_addr[0] = 32'h40; req_we[0] = 1'b1;
      req_size[0] = 2'd2; req_wdata[0] = 32'h12345678;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("wait_no_valid", 32'(vld_a), 32'd0);
      rst_n = 1'b0; #1;
      chk("midrst_ready", 32'(rdy_a), 32'd1);
      chk("midrst_valid", 32'(vld_a), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("ready_after_midrst", 32'(rdy_a), 32'd1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin @(negedge clk); if (vld_a) seen++; end
      chk("dropped_rsp", 32'(seen), 32'd0);
      xfer(0, 32'h40, 1'b0, 2'd2, 1'b0, 32'd0, 0);

      // randomized traffic on the LATENCY=2 instance
      for (int k = 0; k < 80; k++) begin
         a = ($urandom_range(0, 9) == 0) ? 32'(4 * DEPTH + $urandom_range(0, 255))
                                         : 32'($urandom_range(0, 127));
         xfer(0, a, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
              ($urandom_range(0, 7) == 0) ? 2 : 0);
      end

      // LATENCY=0 instance: request held valid, ready tied high -> one accept per 2 cycles
      req_valid[1] = 1'b1;
      prev = 0;
      for (int k = 0; k < 24; k++) begin
         if (k < 8) begin
            a = 32'(4 * k); sz = 2'd2; req_we[1] = 1'b1;
         end else begin
            sz = 2'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 31)) & ~32'((sz == 2'd2) ? 3 : (sz == 2'd1) ? 1 : 0);
            req_we[1] = (k % 5 == 0);
         end
         req_addr[1] = a; req_size[1] = sz; req_uns[1] = 1'($urandom); req_wdata[1] = $urandom;
         mdl_access(1, a, req_we[1], sz, req_uns[1], req_wdata[1], erd, eer);
         n = 0;
         while (!rdy_b && n < 10) begin @(negedge clk); n++; end
         chk("b_accept_timeout", 32'(n < 10), 32'd1);
         @(posedge clk); #1;
         acc = cyc;
         @(negedge clk);
         chk("b_valid", 32'(vld_b), 32'd1);
         chk("b_rdata", rd_b, erd);
         chk("b_err", 32'(er_b), 32'(eer));
         if (k > 0) chk("b_spacing", 32'(acc - prev), 32'd2);
         prev = acc;
      end
      req_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("b_idle", 32'(vld_b), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port: a load/store target with a valid/ready request/response handshake.
- Serves byte, half and word accesses to an internal word array. Storage is little-endian, with a configurable wait-state latency.
- Flags misaligned, out-of-range or illegal-size requests with an error response.
- Sits behind the core's MEM stage; the core (or a bus adapter) is the initiator.

Parameters:
- DATA_WIDTH, 32, data word width; only 32 is supported.
- ADDR_WIDTH, 32, request byte-address width.
- DEPTH_WORDS, 1024, number of 32-bit storage words; must be a power of two.
- LATENCY, 2, wait cycles between request accept and response; 0..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  initiator presents a request.
- req_ready_o  out  1  responder can accept a request.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned (LSBs).
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  initiator accepts the response.
- rsp_rdata_o  out  DATA_WIDTH  load result, extended; 0 for stores and errors.
- rsp_err_o  out  1  request was rejected; no storage effect.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, state = IDLE, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, latency counter = 0, and the latched request is cleared. Storage contents are not reset.
- req_ready_o = 1 only in IDLE, so req_ready_o is 1 from reset release.
- Accept occurs on a clock edge where req_valid_i && req_ready_o. At accept, addr, we, size, unsigned and wdata are latched.
- Error detection at accept (err latched):
  - size = 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - word index addr[ADDR_WIDTH-1:2] >= DEPTH_WORDS.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT on accept if LATENCY > 0; the counter is loaded with LATENCY-1.
  - IDLE -> RESP directly on accept if LATENCY = 0.
  - WAIT decrements the counter each cycle; WAIT -> RESP when the counter = 0.
  - RESP -> IDLE on rsp_ready_i.
- rsp_valid_o rises exactly LATENCY+1 cycles after the accept edge. Minimum request-to-request spacing is LATENCY+2 cycles.
- Commit happens on the edge entering RESP:
  - Store without err: writes the selected lanes. Byte writes lane addr[1:0] with wdata[7:0]. Half writes lanes {addr[1],0}/{addr[1],1} with wdata[15:0]. Word writes all four lanes. Other lanes are unchanged.
  - Load without err: reads the word and extracts the lane (byte at addr[1:0], half at addr[1]), then zero- or sign-extends per the latched unsigned flag. The result is registered into rsp_rdata_o.
  - Error or store: rsp_rdata_o = 0, and rsp_err_o is the latched err.
- While in RESP with rsp_ready_i = 0, rsp_valid_o, rsp_rdata_o and rsp_err_o hold stable. Request inputs are ignored.
- Leaving RESP clears rsp_valid_o, rsp_rdata_o and rsp_err_o.
- rsp_ready_i is ignored while rsp_valid_o = 0.
- Request inputs may change freely after accept; only latched values are used.
- Reset mid-operation (WAIT or RESP): return to IDLE. The pending response is dropped. A store that has not yet entered RESP is not committed.
- Read-after-write to the same address on back-to-back requests returns the new data, because the store commits before its response is issued.

Decomposition:
- Package dmem_pkg:
  - typedef mem_size_e (SZ_BYTE = 2'b00, SZ_HALF, SZ_WORD, SZ_ILLEGAL);
  - typedef dmem_state_e (IDLE, WAIT, RESP);
  - packed struct dmem_req_t holding the latched request fields.
- Sub-module dmem_lane_align (combinational):
  - store path: wdata/size/addr[1:0] -> 4-bit byte mask plus lane-aligned write word;
  - load path: read word/size/addr[1:0]/unsigned -> extended result.
- The top level holds the FSM, counter, request latch and storage array.

Test Plan:
- LATENCY = 2, word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> rsp_valid_o exactly 3 cycles after each accept edge; load rdata 0xDEADBEEF, err 0.
- Byte store 0x80 to addr 0x13, then signed byte load 0x13 -> 0xFFFFFF80; unsigned byte load 0x13 -> 0x00000080. Word load 0x10 -> 0x80ADBEEF.
- Misaligned half load addr 0x21, word store addr 0x22, size = 11, and word addr 4*DEPTH_WORDS -> each gives err = 1, rdata = 0. A follow-up load of 0x20 shows storage unchanged.
- Response backpressure: hold rsp_ready_i = 0 for 5 cycles with req_valid_i = 1 -> rsp outputs stable, req_ready_o = 0 throughout. Exactly one handshake completes when rsp_ready_i rises.
- LATENCY = 0 build: word load -> rsp_valid_o the cycle after accept. With rsp_ready_i tied to 1, back-to-back requests complete every 2 cycles.
- Assert rst_n low during WAIT of a word store of 0x12345678 to addr 0x40 (prior value 0) -> no response. A later load of 0x40 returns 0, and req_ready_o = 1 right after reset release.
